// File: rtl/debug_dump_serializer.sv
// debug_dump_serializer: streams a debug frame (header byte, NWORDS words MSB first) to a UART byte transmitter.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte of all payload bytes to each frame.
module debug_dump_serializer #(
   parameter int NWORDS = 40,
   parameter int SEL_W = 6,
   parameter logic [7:0] HEADER = 8'hA5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [SEL_W-1:0] word_sel,
   input  logic [31:0]      word_in,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   input  logic             tx_done_tick,
   output logic             busy,
   output logic             done
);
`ifdef DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, HDR, LOAD, SEND, WAIT, CSUM, FIN} state_t;
`else
   typedef enum logic [2:0] {IDLE, HDR, LOAD, SEND, WAIT, FIN} state_t;
`endif
   localparam logic [SEL_W-1:0] LAST = SEL_W'(NWORDS - 1);
   state_t state, state_nx;
   logic [31:0] shift;
   logic [1:0] byte_cnt;
   logic hdr_ph;
   logic last_word;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0] csum;
   logic csum_ph;
`endif
   assign last_word = word_sel == LAST;
   assign tx_start = state == HDR || state == SEND
`ifdef DUMP_CHECKSUM_EN
      || state == CSUM
`endif
      ;
   assign busy = state != IDLE && state != FIN;
   assign done = state == FIN;
   // The byte on tx_data is derived from the registers that already hold it, so it stays put through WAIT.
`ifdef DUMP_CHECKSUM_EN
   assign tx_data = hdr_ph ? HEADER
                  : (state == CSUM || (csum_ph && state == WAIT)) ? csum
                  : (state == SEND || state == WAIT) ? shift[31:24] : 8'h00;
`else
   assign tx_data = hdr_ph ? HEADER
                  : (state == SEND || state == WAIT) ? shift[31:24] : 8'h00;
`endif
   // State register; reset abandons any frame in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_nx;
   end
   // Next-state logic; ticks outside WAIT are ignored because only WAIT looks at tx_done_tick.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = HDR;
         HDR:  state_nx = WAIT;
         LOAD: state_nx = SEND;
         SEND: state_nx = WAIT;
         WAIT: if (tx_done_tick) begin
            if (hdr_ph) state_nx = LOAD;
            else if (byte_cnt != 2'd0) state_nx = SEND;
            else if (!last_word) state_nx = LOAD;
`ifdef DUMP_CHECKSUM_EN
            else state_nx = csum_ph ? FIN : CSUM;
`else
            else state_nx = FIN;
`endif
         end
`ifdef DUMP_CHECKSUM_EN
         CSUM: state_nx = WAIT;
`endif
         FIN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // Datapath: word index, byte counter, shift register, header phase and checksum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_sel <= '0;
         byte_cnt <= 2'd0;
         shift <= 32'h0;
         hdr_ph <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum <= 8'h00;
         csum_ph <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               word_sel <= '0;
               byte_cnt <= 2'd0;
               hdr_ph <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
               csum <= 8'h00;
               csum_ph <= 1'b0;
`endif
            end
            LOAD: begin
               shift <= word_in;
               byte_cnt <= 2'd3;
            end
`ifdef DUMP_CHECKSUM_EN
            SEND: csum <= csum ^ shift[31:24];
            CSUM: csum_ph <= 1'b1;
`endif
            WAIT: if (tx_done_tick) begin
               if (hdr_ph) hdr_ph <= 1'b0;
               else if (byte_cnt != 2'd0) begin
                  shift <= {shift[23:0], 8'h00};
                  byte_cnt <= byte_cnt - 2'd1;
               end else if (!last_word) word_sel <= word_sel + SEL_W'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_debug_dump_serializer.sv
// tb_debug_dump_serializer: scoreboard bench with a UART responder model for debug_dump_serializer.
module tb_debug_dump_serializer;
   localparam int NW = 40;
`ifdef DUMP_CHECKSUM_EN
   localparam int FLEN = 2 + 4 * NW;
`else
   localparam int FLEN = 1 + 4 * NW;
`endif
   logic clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic tx_start, tx_done_tick, busy, done;
   logic [5:0] word_sel;
   logic [31:0] word_in;
   logic [7:0] tx_data;
   logic tick_uart = 1'b0, tick_spur = 1'b0;
   logic [31:0] words [64];
   logic [7:0] exp_q [$];
   logic [7:0] last_cs = 8'h00;
   int total = 0, bad = 0, n_tx = 0, n_done = 0, hold_err = 0, repulse = 0, max_sel = 0;
   int delay = 10, tick_w = 1, cd = 0, tick_left = 0, d0 = 0;
   logic holding = 1'b0;
   logic [7:0] held = 8'h00;

   always #5 clk = ~clk;
   assign word_in = words[word_sel];
   assign tx_done_tick = tick_uart | tick_spur;

   debug_dump_serializer dut (
      .clk(clk), .reset(reset), .start(start), .word_sel(word_sel), .word_in(word_in),
      .tx_start(tx_start), .tx_data(tx_data), .tx_done_tick(tx_done_tick), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor, scoreboard pop and UART responder, sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         holding = 1'b0;
         cd = 0;
         tick_left = 0;
         tick_uart = 1'b0;
      end else begin
         if (tx_done_tick) holding = 1'b0;
         else if (holding && !tx_start && tx_data !== held) hold_err++;
         if (tx_start) begin
            if (holding) repulse++;
            n_tx++;
            if (exp_q.size() == 0) check("extra_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
            else check("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            held = tx_data;
            holding = 1'b1;
         end
         if (done) begin
            n_done++;
            check("busy_at_done", {31'h0, busy}, 32'h0);
         end
         if (int'(word_sel) > max_sel) max_sel = int'(word_sel);
         if (tick_left > 0) tick_left--;
         if (cd > 0) begin
            cd--;
            if (cd == 0) tick_left = tick_w;
         end
         if (tx_start) cd = delay;
         tick_uart = tick_left > 0;
      end
   end

   task automatic push_frame();
      logic [7:0] cs;
      logic [31:0] w;
      cs = 8'h00;
      exp_q.push_back(8'hA5);
      for (int i = 0; i < NW; i++) begin
         w = words[i];
         for (int b = 3; b >= 0; b--) begin
            exp_q.push_back(w[b*8 +: 8]);
            cs ^= w[b*8 +: 8];
         end
      end
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
      last_cs = cs;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic begin_frame();
      n_tx = 0;
      d0 = n_done;
      push_frame();
      pulse_start();
   endtask

   task automatic wait_tx(input int n, input int limit);
      for (int i = 0; i < limit && n_tx < n; i++) @(posedge clk);
      #2;
      check("reach_byte", {31'h0, n_tx >= n}, 32'h1);
   endtask

   task automatic end_frame(input string tag, input int limit);
      for (int i = 0; i < limit && n_done == d0; i++) @(posedge clk);
      repeat (30) @(posedge clk);
      #2;
      check({tag, "_ntx"}, n_tx, FLEN);
      check({tag, "_done"}, n_done - d0, 1);
      check({tag, "_q_empty"}, exp_q.size(), 0);
      check({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) words[i] = 32'h0;
      words[0] = 32'h1234_5678;
      #12;
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_tx_start", {31'h0, tx_start}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_word_sel", {26'h0, word_sel}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      tick_spur = 1'b1;
      @(negedge clk);
      tick_spur = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("idle_tick_busy", {31'h0, busy}, 32'h0);
      check("idle_tick_ntx", n_tx, 0);
      begin_frame();
      end_frame("frame_a", 6000);
      for (int i = 0; i < NW; i++) words[i] = $urandom;
      delay = 3;
      tick_w = 2;
      begin_frame();
      wait_tx(50, 2000);
      pulse_start();
      end_frame("frame_b", 4000);
      repeat (50) @(posedge clk);
      #2;
      check("no_second_frame", n_tx, FLEN);
      delay = 10;
      tick_w = 1;
      begin_frame();
      wait_tx(20, 2000);
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("midrst_tx_start", {31'h0, tx_start}, 32'h0);
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_word_sel", {26'h0, word_sel}, 32'h0);
      exp_q.delete();
      repeat (5) @(posedge clk);
      #2;
      check("midrst_no_done", n_done, d0);
      @(negedge clk);
      reset = 1'b1;
      begin_frame();
      end_frame("frame_c", 6000);
      delay = 1000;
      begin_frame();
      wait_tx(1, 50);
      delay = 5;
      repeat (500) @(posedge clk);
      #2;
      check("slow_tx_data", {24'h0, tx_data}, 32'hA5);
      check("slow_tx_start", {31'h0, tx_start}, 32'h0);
      check("slow_ntx", n_tx, 1);
      end_frame("frame_d", 4000);
      check("max_word_sel", max_sel, NW - 1);
      check("hold_err", hold_err, 0);
      check("repulse", repulse, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
